// File: rtl/jarbitrary_seq_checker.sv
// Sink-side checker for the 3-bit sequence 0,1,2,3,6,5,7: decodes, tracks, locks, counts errors.
// Optional macro JARB_SEQ_STATS_EN adds the seq_count output (wraps since last loss of lock).
module jarbitrary_seq_checker #(
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  output logic [2:0]       idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             wrap
`ifdef JARB_SEQ_STATS_EN
  ,
  output logic [15:0]      seq_count
`endif
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [2:0]       LockCntC = 3'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ErrMaxC  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ErrOneC  = {{(ERR_W-1){1'b0}}, 1'b1};

  // Returns {legal, index}; code 3'b100 is the only illegal value.
  function automatic logic [3:0] decode(input logic [2:0] code);
    logic [3:0] r;
    case (code)
      3'b000:  r = {1'b1, 3'd0};
      3'b001:  r = {1'b1, 3'd1};
      3'b010:  r = {1'b1, 3'd2};
      3'b011:  r = {1'b1, 3'd3};
      3'b110:  r = {1'b1, 3'd4};
      3'b101:  r = {1'b1, 3'd5};
      3'b111:  r = {1'b1, 3'd6};
      default: r = {1'b0, 3'd0};
    endcase
    return r;
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] i);
    return (i == 3'd6) ? 3'd0 : i + 3'd1;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       exp_q, exp_d;
  logic [2:0]       good_q, good_d;
  logic [2:0]       idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             lock_lost_s;
  logic             legal_s;
  logic [2:0]       dec_idx_s;
  logic [2:0]       good_inc_s;

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    good_d      = good_q;
    idx_d       = idx_q;
    idx_valid_d = 1'b0;
    err_d       = 1'b0;
    wrap_d      = 1'b0;
    lock_lost_s = 1'b0;
    {legal_s, dec_idx_s} = decode(in_code);
    good_inc_s  = good_q + 3'd1;

    if (in_valid) begin
      idx_valid_d = 1'b1;
      if (legal_s) begin
        idx_d = dec_idx_s;
      end else begin
        idx_d = idx_q;
      end
      case (state_q)
        HUNT: begin
          if (legal_s) begin
            exp_d   = succ(dec_idx_s);
            good_d  = 3'd0;
            state_d = SYNC;
          end else begin
            err_d = 1'b1;
          end
        end
        SYNC: begin
          if (!legal_s) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (dec_idx_s == exp_q) begin
            exp_d = succ(dec_idx_s);
            if (good_inc_s == LockCntC) begin
              good_d  = 3'd0;
              state_d = LOCKED;
            end else begin
              good_d = good_inc_s;
            end
          end else begin
            // Silent resync: this code becomes the new reference point.
            exp_d  = succ(dec_idx_s);
            good_d = 3'd0;
          end
        end
        LOCKED: begin
          if (legal_s && (dec_idx_s == exp_q)) begin
            exp_d  = succ(dec_idx_s);
            wrap_d = (dec_idx_s == 3'd6);
          end else begin
            err_d       = 1'b1;
            state_d     = HUNT;
            lock_lost_s = 1'b1;
          end
        end
        default: begin
          state_d = HUNT;
          good_d  = 3'd0;
        end
      endcase
    end else begin
      idx_valid_d = 1'b0;
    end

    if (err_d && (err_count_q != ErrMaxC)) begin
      err_count_d = err_count_q + ErrOneC;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HUNT;
      exp_q       <= 3'd0;
      good_q      <= 3'd0;
      idx_q       <= 3'd0;
      idx_valid_q <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
      err_count_q <= {ERR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      good_q      <= good_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
      err_count_q <= err_count_d;
    end
  end

`ifdef JARB_SEQ_STATS_EN
  logic [15:0] seq_count_q, seq_count_d;

  always_comb begin
    if (lock_lost_s) begin
      seq_count_d = 16'd0;
    end else if (wrap_d) begin
      seq_count_d = seq_count_q + 16'd1;
    end else begin
      seq_count_d = seq_count_q;
    end
  end

  // Completed-sequence counter, cleared whenever lock is lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      seq_count_q <= 16'd0;
    end else begin
      seq_count_q <= seq_count_d;
    end
  end

  assign seq_count = seq_count_q;
`endif

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign err_count = err_count_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_jarbitrary_seq_checker.sv
// Self-checking bench for jarbitrary_seq_checker: vector table, directed corners, random vs. model.
module tb_jarbitrary_seq_checker;

  localparam int LOCK_CNT = 3;
  localparam int ERR_W    = 8;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             clock = 1'b0;
  logic             reset, in_valid;
  logic [2:0]       in_code;
  logic [2:0]       idx;
  logic             idx_valid, locked, err, wrap;
  logic [ERR_W-1:0] err_count;
`ifdef JARB_SEQ_STATS_EN
  logic [15:0]      seq_count;
`endif

  jarbitrary_seq_checker #(.LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_code(in_code),
    .idx(idx), .idx_valid(idx_valid), .locked(locked), .err(err),
    .err_count(err_count), .wrap(wrap)
`ifdef JARB_SEQ_STATS_EN
    , .seq_count(seq_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: the sequence as a table, positions found by search.
  int seq_tab [7] = '{0, 1, 2, 3, 6, 5, 7};
  int m_mode;  // 0 hunting, 1 syncing, 2 locked
  int m_next, m_run, m_idx, m_errc, m_seqc;
  bit m_iv, m_err, m_wrap;

  function automatic int pos_of(input int code);
    for (int i = 0; i < 7; i++) if (seq_tab[i] == code) return i;
    return -1;
  endfunction

  task automatic model_step(input bit r, input bit v, input int code);
    int p;
    if (r) begin
      m_mode = 0; m_next = 0; m_run = 0; m_idx = 0; m_errc = 0; m_seqc = 0;
      m_iv = 0; m_err = 0; m_wrap = 0;
      return;
    end
    m_iv = v; m_err = 0; m_wrap = 0;
    if (!v) return;
    p = pos_of(code);
    if (p >= 0) m_idx = p;
    if (m_mode == 0) begin
      if (p < 0) m_err = 1;
      else begin m_next = (p + 1) % 7; m_run = 0; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (p < 0) begin m_err = 1; m_mode = 0; end
      else if (p == m_next) begin
        m_run++; m_next = (p + 1) % 7;
        if (m_run == LOCK_CNT) begin m_mode = 2; m_run = 0; end
      end else begin m_next = (p + 1) % 7; m_run = 0; end
    end else begin
      if (p >= 0 && p == m_next) begin
        m_next = (p + 1) % 7;
        if (p == 6) begin m_wrap = 1; m_seqc = (m_seqc + 1) % 65536; end
      end else begin m_err = 1; m_mode = 0; m_seqc = 0; end
    end
    if (m_err && m_errc < ERR_MAX) m_errc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one cycle, advances the model, samples 1 time unit after the edge.
  task automatic step(input bit r, input bit v, input int code);
    reset = r; in_valid = v; in_code = 3'(code);
    @(posedge clock);
    #1;
    model_step(r, v, code);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".idx"}, idx, m_idx);
    chk({tag, ".idx_valid"}, idx_valid, m_iv);
    chk({tag, ".locked"}, locked, m_mode == 2);
    chk({tag, ".err"}, err, m_err);
    chk({tag, ".wrap"}, wrap, m_wrap);
    chk({tag, ".err_count"}, err_count, m_errc);
`ifdef JARB_SEQ_STATS_EN
    chk({tag, ".seq_count"}, seq_count, m_seqc);
`endif
  endtask

  task automatic step_chk(input string tag, input bit r, input bit v, input int code);
    step(r, v, code);
    chk_model(tag);
  endtask

  typedef struct {
    bit r; bit v; int code;
    int e_idx; bit e_iv; bit e_lk; bit e_err; bit e_wrap; int e_errc;
  } vec_t;

  vec_t vt [$];
  int   last_pos;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_code = 3'd0;
    // Plan 1: full sequence lock and wrap; plan 2: mismatch while locked, then relock.
    vt.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{0, 1, 0, 0, 1, 0, 0, 0, 0});
    vt.push_back('{0, 1, 1, 1, 1, 0, 0, 0, 0});
    vt.push_back('{0, 1, 2, 2, 1, 0, 0, 0, 0});
    vt.push_back('{0, 1, 3, 3, 1, 1, 0, 0, 0});
    vt.push_back('{0, 1, 6, 4, 1, 1, 0, 0, 0});
    vt.push_back('{0, 1, 5, 5, 1, 1, 0, 0, 0});
    vt.push_back('{0, 1, 7, 6, 1, 1, 0, 1, 0});
    vt.push_back('{0, 1, 0, 0, 1, 1, 0, 0, 0});
    vt.push_back('{0, 1, 1, 1, 1, 1, 0, 0, 0});
    vt.push_back('{0, 1, 2, 2, 1, 1, 0, 0, 0});
    vt.push_back('{0, 1, 3, 3, 1, 1, 0, 0, 0});
    vt.push_back('{0, 1, 5, 5, 1, 0, 1, 0, 1});
    vt.push_back('{0, 0, 0, 5, 0, 0, 0, 0, 1});
    vt.push_back('{0, 1, 0, 0, 1, 0, 0, 0, 1});
    vt.push_back('{0, 1, 1, 1, 1, 0, 0, 0, 1});
    vt.push_back('{0, 1, 2, 2, 1, 0, 0, 0, 1});
    vt.push_back('{0, 1, 3, 3, 1, 1, 0, 0, 1});

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].r, vt[i].v, vt[i].code);
      chk($sformatf("vec%0d.idx", i), idx, vt[i].e_idx);
      chk($sformatf("vec%0d.idx_valid", i), idx_valid, vt[i].e_iv);
      chk($sformatf("vec%0d.locked", i), locked, vt[i].e_lk);
      chk($sformatf("vec%0d.err", i), err, vt[i].e_err);
      chk($sformatf("vec%0d.wrap", i), wrap, vt[i].e_wrap);
      chk($sformatf("vec%0d.err_count", i), err_count, vt[i].e_errc);
    end

    // Plan 3: illegal code in HUNT keeps idx, pulses err, saturates the counter.
    step_chk("p3.rst", 1, 0, 0);
    step_chk("p3.legal", 0, 1, 2);
    step_chk("p3.bad_sync", 0, 1, 4);
    for (int i = 0; i < 260; i++) begin
      step_chk("p3.bad", 0, 1, 4);
      chk("p3.idx_hold", idx, 2);
    end
    chk("p3.sat", err_count, ERR_MAX);
    step_chk("p3.legal_after", 0, 1, 0);
    chk("p3.hunt_left", locked, 0);

    // Plan 4: silent resync on 6, then lock after three correct successors.
    step_chk("p4.rst", 1, 0, 0);
    step_chk("p4.c0", 0, 1, 0);
    step_chk("p4.c1", 0, 1, 1);
    step_chk("p4.c6", 0, 1, 6);
    chk("p4.no_err", err, 0);
    step_chk("p4.c5", 0, 1, 5);
    step_chk("p4.c7", 0, 1, 7);
    chk("p4.not_yet", locked, 0);
    step_chk("p4.c0b", 0, 1, 0);
    chk("p4.lock", locked, 1);

    // Plan 5: valid/idle/idle gaps while locked.
    last_pos = 0;
    for (int i = 1; i <= 12; i++) begin
      step_chk("p5.v", 0, 1, seq_tab[(last_pos + i) % 7]);
      chk("p5.lock_v", locked, 1);
      step_chk("p5.idle1", 0, 0, 3'(i));
      step_chk("p5.idle2", 0, 0, 4);
      chk("p5.lock_i", locked, 1);
    end

    // Plan 6: reset mid-lock after three wraps.
    step_chk("p6.rst", 1, 0, 0);
    step_chk("p6.bad", 0, 1, 4);
    for (int i = 0; i < 21; i++) step_chk("p6.seq", 0, 1, seq_tab[i % 7]);
    chk("p6.locked_before", locked, 1);
    chk("p6.errc_before", err_count, 1);
`ifdef JARB_SEQ_STATS_EN
    chk("p6.seq_before", seq_count, 3);
`endif
    step_chk("p6.rst_mid", 1, 1, 0);
    chk("p6.locked_after", locked, 0);
    chk("p6.errc_after", err_count, 0);
`ifdef JARB_SEQ_STATS_EN
    chk("p6.seq_after", seq_count, 0);
`endif

    // Random traffic, mostly in-sequence so lock is reached and lost repeatedly.
    last_pos = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, v;
      int code;
      r = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 99) < 85) code = seq_tab[(last_pos + 1) % 7];
      else code = $urandom_range(0, 7);
      if (v && pos_of(code) >= 0) last_pos = pos_of(code);
      step_chk("rnd", r, v, code);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jarbitrary_seq_checker.md
Name: jarbitrary_seq_checker

Overview:
Receive-side companion to the arbitrary 3-bit sequence generator, which emits the repeating code sequence 0,1,2,3,6,5,7.
- Decodes each incoming code back to its position index (0..6).
- Checks that each code follows the previous one in the sequence, and locks after a run of correct codes.
- Reports errors with a pulse and a saturating count.
- Sits at the sink end of the generator link, in test and bring-up datapaths.

Parameters:
- LOCK_CNT, 3, consecutive correct successor codes required in SYNC before entering LOCKED; legal range 1..7.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_code is sampled this cycle
- in_code  input  3  received sequence code
- idx  output  3  decoded position index of the last sampled code
- idx_valid  output  1  idx updated this cycle (1-cycle pulse)
- locked  output  1  checker is in LOCKED state
- err  output  1  1-cycle error pulse
- err_count  output  ERR_W  saturating count of err pulses
- wrap  output  1  1-cycle pulse when a locked sequence completes (code 7 accepted)
- seq_count  output  16  only when JARB_SEQ_STATS_EN is defined; see Optional Feature

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high. Reset dominates every other event in the same cycle.
- Reset values: idx=0, idx_valid=0, locked=0, err=0, err_count=0, wrap=0, seq_count=0. State=HUNT, expected=0, good_cnt=0.
- Decode map (code->idx):
  - 000->0, 001->1, 010->2, 011->3, 110->4, 101->5, 111->6.
  - 100 is illegal. For an illegal code, idx holds its previous value, but idx_valid still pulses.
- Successor: expected = (idx==6) ? 0 : idx+1. Compare in the index domain.
- Latency: all outputs are registered. A code sampled at edge N produces idx, idx_valid, err, wrap and locked on the cycle after edge N.
- in_valid=0: no state, counter or idx change; idx_valid=0, err=0, wrap=0.
- FSM states: HUNT, SYNC, LOCKED. The state at the sampling edge selects the rule below.
  - HUNT, legal code: expected=succ(idx), good_cnt=0, go to SYNC. If LOCK_CNT==1, the next correct code locks.
  - HUNT, illegal code: err=1, stay in HUNT.
  - SYNC, code matches expected: good_cnt++ and expected advances. When good_cnt reaches LOCK_CNT, go to LOCKED and reset good_cnt to 0.
  - SYNC, legal code that does not match: resync silently. Reload expected from this code, set good_cnt=0, stay in SYNC, no err.
  - SYNC, illegal code: err=1, go to HUNT.
  - LOCKED, code matches: expected advances. If the code is 111, wrap=1.
  - LOCKED, mismatch or illegal code: err=1, go to HUNT (locked drops the next cycle). The offending code is not reused for resync.
- err_count: increments on every err pulse and saturates at 2^ERR_W-1 (no wrap-around).
- locked=1 exactly while state==LOCKED.
- Reset asserted mid-sequence or mid-lock: all outputs return to their reset values the following cycle.

Optional Feature:
- Macro: JARB_SEQ_STATS_EN.
- Defined:
  - Adds output seq_count[15:0], incremented with every wrap pulse. It wraps modulo 2^16.
  - seq_count clears on reset and on every LOCKED->HUNT transition.
- Not defined: port, register and logic are all absent; every other behaviour is identical.

Test Plan:
1. Reset, then send codes 0,1,2,3,6,5,7,0 with in_valid=1 every cycle, LOCK_CNT=3:
   - idx = 0,1,2,3,4,5,6,0.
   - locked rises the cycle after code 3 is sampled.
   - wrap pulses once, after code 7.
   - err never pulses.
2. Lock, then inject code 5 where 6 is expected:
   - err pulses once; err_count 0->1.
   - locked falls.
   - Restart with codes 0,1,2,3: relock.
3. Send code 100 while in HUNT:
   - err=1, idx_valid=1, idx unchanged, state stays HUNT.
   - Repeat 260 times with ERR_W=8: err_count saturates at 255.
4. In SYNC, send 0,1,6 then 5,7:
   - No err (silent resync on 6).
   - Lock after the 3rd correct successor following 6.
5. in_valid gaps (valid, idle, idle, valid, ...) while locked: no err, idx_valid only on valid cycles, lock held.
6. Assert reset for one cycle mid-lock (and, with JARB_SEQ_STATS_EN, after 3 wraps):
   - Next cycle: locked=0, err_count=0.
   - With the macro: seq_count reads 3 before reset and 0 after it.
